ldst_memory_port: RTL
=====================

// Module: ldst_memory_port
// PURPOSE
// - Load/store port between the execute stage and the data-memory bus; sits directly upstream of the load AFE (sign-extend) stage.
// - Accepts one load/store command at a time and drives a word-aligned memory request with a byte-lane mask.
// - For loads, extracts the addressed byte/half/word and right-justifies it zero-extended, then hands it on with the command's AFE code and destination.
// PARAMETERS
// P_DEST_W     5   width of the destination-register tag
// P_BIG_ENDIAN 1   1: byte at addr[1:0]=0 is on bits [31:24]; 0: on bits [7:0]
// PORTS
// iCLOCK          in   1        clock, all state updates on rising edge
// inRESET         in   1        synchronous active-low reset
// iFLUSH          in   1        pipeline flush, synchronous
// iEXE_VALID      in   1        command valid
// oEXE_BUSY       out  1        port cannot accept a command
// iEXE_RW         in   1        0=load, 1=store
// iEXE_SIZE       in   2        00=byte 01=half 10=word 11=reserved
// iEXE_ADDR       in   32       byte address
// iEXE_DATA       in   32       store data, right-justified
// iEXE_AFE_CODE   in   4        AFE code forwarded with load data
// iEXE_DEST       in   P_DEST_W load destination tag
// oDATA_REQ       out  1        memory request
// iDATA_LOCK      in   1        memory busy; request not taken while high
// oDATA_RW        out  1        0=read, 1=write
// oDATA_MASK      out  4        byte-lane enables
// oDATA_ADDR      out  32       word address ({addr[31:2],2'b00})
// oDATA_DATA      out  32       store data replicated into the selected lanes
// iDATA_VALID     in   1        read data valid
// iDATA_DATA      in   32       read data word
// oLOAD_VALID     out  1        one-cycle pulse: aligned load result valid
// oLOAD_DATA      out  32       aligned, zero-extended load data
// oLOAD_AFE_CODE  out  4        AFE code of the completed load
// oLOAD_DEST      out  P_DEST_W tag of the completed load
// oSTORE_DONE     out  1        one-cycle pulse: store accepted by memory
// oFAULT_ALIGN    out  1        one-cycle pulse: misaligned/reserved-size command rejected
// BEHAVIOUR
// - Reset (inRESET=0 at edge): state IDLE; every output 0, including oDATA_* and oLOAD_*.
// - States: IDLE, REQ, WAIT, DRAIN. oEXE_BUSY = (state != IDLE), combinational from state.
// - IDLE: on iEXE_VALID, register the command. Alignment check: half needs addr[0]=0, word needs addr[1:0]=0, size 11 always faults.
//   - Faulting command: pulse oFAULT_ALIGN the next cycle, issue no request, stay IDLE.
//   - Otherwise go to REQ with oDATA_* registered.
// - REQ: oDATA_REQ=1 and oDATA_* held stable until a cycle with iDATA_LOCK=0 (request taken).
//   - Store taken: oSTORE_DONE pulses the next cycle; go to IDLE (posted write).
//   - Load taken: go to WAIT.
// - WAIT: on iDATA_VALID, extract the lane selected by addr[1:0]/size. Next cycle: oLOAD_VALID=1, oLOAD_DATA/AFE_CODE/DEST valid; go to IDLE.
//   - Latency: load data reaches oLOAD_* 1 cycle after iDATA_VALID. oLOAD_* hold their last value when not valid.
// - Mask (big-endian): byte -> 4'b1000>>addr[1:0]; half -> addr[1]?4'b0011:4'b1100; word -> 4'b1111. P_BIG_ENDIAN=0 mirrors the lanes.
// - Store data: byte replicated x4, half replicated x2.
// - iFLUSH (highest priority after reset):
//   - IDLE: the command in that cycle is ignored.
//   - REQ: before the request is taken, drop oDATA_REQ next cycle and go to IDLE. A request taken in the same cycle counts as taken, then is handled as in WAIT/store.
//   - WAIT: go to DRAIN. DRAIN swallows the next iDATA_VALID with no oLOAD_VALID, then goes to IDLE.
//   - No oSTORE_DONE/oLOAD_VALID/oFAULT_ALIGN pulse in the cycle after a flush, except the store-done of a store taken in the flush cycle.
// - iDATA_VALID outside WAIT/DRAIN is ignored.
// - Reset mid-operation aborts everything; a late iDATA_VALID is then ignored.
// STRUCTURE
// - core.h: LDST_SIZE_BYTE/HALF/WORD, FSM state encodings (2-bit), AFE_LDST_* codes (shared with the AFE stage).
// - Sub-module ldst_byte_align (combinational): size, addr[1:0] and endianness -> mask, store-lane replication, load extraction.
// - This block holds the FSM and registers only.
// TESTING
// - Word load at 0x100, lock=0, iDATA_VALID 3 cycles later with 0x11223344 -> oLOAD_VALID 1 cycle later, oLOAD_DATA=0x11223344, DEST/AFE echoed.
// - Byte load at 0x103, read word 0xAABBCCF0 -> oDATA_MASK=0001, oLOAD_DATA=0x000000F0; half load at 0x102 -> mask 0011, data 0x0000CCF0.
// - Byte store 0x5A at 0x101, iDATA_LOCK high 4 cycles -> oDATA_REQ held 5 cycles, ADDR=0x100, MASK=0100, DATA=0x5A5A5A5A; oSTORE_DONE 1 cycle after lock drops.
// - Word load at 0x102 and a size=11 command -> oFAULT_ALIGN pulse each, oDATA_REQ never asserted, oEXE_BUSY stays 0.
// - Load in WAIT, iFLUSH, then iDATA_VALID -> no oLOAD_VALID; a following load completes normally.
// - inRESET low while in REQ -> next cycle all outputs 0 and state IDLE; a stray iDATA_VALID afterwards produces no oLOAD_VALID.

Source files
------------

// File: rtl/ldst_memory_port_pkg.sv
// ldst_memory_port_pkg: size codes, FSM encodings and AFE codes shared by the load/store port and the AFE stage.
package ldst_memory_port_pkg;
    localparam logic [1:0] LDST_SIZE_BYTE = 2'b00;
    localparam logic [1:0] LDST_SIZE_HALF = 2'b01;
    localparam logic [1:0] LDST_SIZE_WORD = 2'b10;
    localparam logic [1:0] LDST_SIZE_RSVD = 2'b11;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;
    localparam logic [3:0] AFE_LDST_NONE  = 4'h0;
    localparam logic [3:0] AFE_LDST_SBYTE = 4'h1;
    localparam logic [3:0] AFE_LDST_SHALF = 4'h2;
    localparam logic [3:0] AFE_LDST_UBYTE = 4'h3;
    localparam logic [3:0] AFE_LDST_UHALF = 4'h4;
    typedef struct packed {
        logic       rw;
        logic [1:0] size;
        logic [1:0] off;
        logic [3:0] afe_code;
    } cmd_t;
endpackage

// File: rtl/ldst_memory_port_if.sv
// ldst_memory_port_if: execute-side command, memory bus and load/store result signals of the load/store port.
interface ldst_memory_port_if #(parameter int P_DEST_W = 5);
    logic                flush;
    logic                exe_valid;
    logic                exe_busy;
    logic                exe_rw;
    logic [1:0]          exe_size;
    logic [31:0]         exe_addr;
    logic [31:0]         exe_data;
    logic [3:0]          exe_afe_code;
    logic [P_DEST_W-1:0] exe_dest;
    logic                data_req;
    logic                data_lock;
    logic                data_rw;
    logic [3:0]          data_mask;
    logic [31:0]         data_addr;
    logic [31:0]         data_wdata;
    logic                data_valid;
    logic [31:0]         data_rdata;
    logic                load_valid;
    logic [31:0]         load_data;
    logic [3:0]          load_afe_code;
    logic [P_DEST_W-1:0] load_dest;
    logic                store_done;
    logic                fault_align;
    modport master (
        input  flush, exe_valid, exe_rw, exe_size, exe_addr, exe_data, exe_afe_code, exe_dest,
        input  data_lock, data_valid, data_rdata,
        output exe_busy, data_req, data_rw, data_mask, data_addr, data_wdata,
        output load_valid, load_data, load_afe_code, load_dest, store_done, fault_align
    );
    modport slave (
        output flush, exe_valid, exe_rw, exe_size, exe_addr, exe_data, exe_afe_code, exe_dest,
        output data_lock, data_valid, data_rdata,
        input  exe_busy, data_req, data_rw, data_mask, data_addr, data_wdata,
        input  load_valid, load_data, load_afe_code, load_dest, store_done, fault_align
    );
endinterface

// File: rtl/ldst_byte_align.sv
// ldst_byte_align: byte-lane mask, store-lane replication, load extraction and alignment check.
module ldst_byte_align import ldst_memory_port_pkg::*; #(
    parameter bit P_BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  mask,
    output logic [31:0] lanes,
    output logic [31:0] extracted,
    output logic        fault
);
    logic [2:0]  nbytes;
    logic [2:0]  lane;
    logic [3:0]  be_mask;
    logic [31:0] keep;
    always_comb begin
        nbytes    = size == LDST_SIZE_BYTE ? 3'd1 : size == LDST_SIZE_HALF ? 3'd2 : 3'd4;
        be_mask   = size == LDST_SIZE_BYTE ? 4'b1000 >> off :
                    size == LDST_SIZE_HALF ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        mask      = P_BIG_ENDIAN ? be_mask : {be_mask[0], be_mask[1], be_mask[2], be_mask[3]};
        // lane = index of the least significant byte of the addressed field
        lane      = P_BIG_ENDIAN ? 3'd4 - nbytes - {1'b0, off} : {1'b0, off};
        keep      = size == LDST_SIZE_BYTE ? 32'h0000_00ff : size == LDST_SIZE_HALF ? 32'h0000_ffff : 32'hffff_ffff;
        extracted = (read_data >> {lane, 3'b000}) & keep;
        lanes     = size == LDST_SIZE_BYTE ? {4{store_data[7:0]}} :
                    size == LDST_SIZE_HALF ? {2{store_data[15:0]}} : store_data;
        fault     = size == LDST_SIZE_RSVD || (size == LDST_SIZE_HALF && off[0]) ||
                    (size == LDST_SIZE_WORD && off != 2'b00);
    end
endmodule

// File: rtl/ldst_memory_port.sv
// ldst_memory_port: one-at-a-time load/store FSM between execute and the data-memory bus.
module ldst_memory_port import ldst_memory_port_pkg::*; #(
    parameter int P_DEST_W     = 5,
    parameter bit P_BIG_ENDIAN = 1'b1
) (
    input logic clk,
    input logic rst_n,
    ldst_memory_port_if.master bus
);
    logic [1:0]          state;
    cmd_t                cmd;
    logic [P_DEST_W-1:0] dest;
    logic                idle;
    logic [1:0]          a_size;
    logic [1:0]          a_off;
    logic [3:0]          mask;
    logic [31:0]         lanes;
    logic [31:0]         extracted;
    logic                fault;
    // one aligner serves both the incoming command (IDLE) and the pending load
    always_comb begin
        idle   = state == ST_IDLE;
        a_size = idle ? bus.exe_size : cmd.size;
        a_off  = idle ? bus.exe_addr[1:0] : cmd.off;
    end
    assign bus.exe_busy = !idle;
    ldst_byte_align #(.P_BIG_ENDIAN(P_BIG_ENDIAN)) u_align (
        .size(a_size),
        .off(a_off),
        .store_data(bus.exe_data),
        .read_data(bus.data_rdata),
        .mask(mask),
        .lanes(lanes),
        .extracted(extracted),
        .fault(fault)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            cmd               <= '0;
            dest              <= '0;
            bus.data_req      <= 1'b0;
            bus.data_rw       <= 1'b0;
            bus.data_mask     <= '0;
            bus.data_addr     <= '0;
            bus.data_wdata    <= '0;
            bus.load_valid    <= 1'b0;
            bus.load_data     <= '0;
            bus.load_afe_code <= AFE_LDST_NONE;
            bus.load_dest     <= '0;
            bus.store_done    <= 1'b0;
            bus.fault_align   <= 1'b0;
        end else begin
            bus.load_valid  <= 1'b0;
            bus.store_done  <= 1'b0;
            bus.fault_align <= 1'b0;
            case (state)
                ST_IDLE: if (bus.exe_valid && !bus.flush) begin
                    if (fault) bus.fault_align <= 1'b1;
                    else begin
                        state          <= ST_REQ;
                        cmd            <= '{rw: bus.exe_rw, size: bus.exe_size, off: bus.exe_addr[1:0], afe_code: bus.exe_afe_code};
                        dest           <= bus.exe_dest;
                        bus.data_req   <= 1'b1;
                        bus.data_rw    <= bus.exe_rw;
                        bus.data_mask  <= mask;
                        bus.data_addr  <= {bus.exe_addr[31:2], 2'b00};
                        bus.data_wdata <= lanes;
                    end
                end
                // a request taken in the flush cycle still completes; a flushed load drains its read
                ST_REQ: if (!bus.data_lock) begin
                    bus.data_req   <= 1'b0;
                    bus.store_done <= cmd.rw;
                    state          <= cmd.rw ? ST_IDLE : bus.flush ? ST_DRAIN : ST_WAIT;
                end else if (bus.flush) begin
                    bus.data_req <= 1'b0;
                    state        <= ST_IDLE;
                end
                ST_WAIT: if (bus.flush) state <= bus.data_valid ? ST_IDLE : ST_DRAIN;
                else if (bus.data_valid) begin
                    bus.load_valid    <= 1'b1;
                    bus.load_data     <= extracted;
                    bus.load_afe_code <= cmd.afe_code;
                    bus.load_dest     <= dest;
                    state             <= ST_IDLE;
                end
                default: if (bus.data_valid) state <= ST_IDLE;
            endcase
        end
    end
endmodule
